// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction fetch front end.
//   fetch_entry_t : one buffered fetch, {pc, instr}
//   FETCH_NOP     : canonical RV32I no-op (addi x0, x0, 0)
//   FETCH_MASK    : byte-enable mask for full-word instruction reads
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W  = 32;
    localparam int unsigned FETCH_INSTR_W = 32;

    localparam logic [31:0] FETCH_NOP  = 32'h0000_0013;
    localparam logic [3:0]  FETCH_MASK = 4'b1111;

    // The entry layout is fixed at 32-bit PC and 32-bit instruction; the top
    // level casts its ADDRESS/INSTRUCTION-wide values into and out of it.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
//   clk, rst     : clock and asynchronous active-high reset
//   push, entry  : write push_entry at the tail
//   pop          : remove the head entry
//   flush        : drop all entries (overrides push and pop)
//   head_entry   : entry at the head (registered storage)
//   count        : number of valid entries
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head_entry,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(32'd1);
        end
        return nxt;
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {$bits(fetch_entry_t){1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/fetch_queue_checker.sv
// Protocol checks for the fetch queue unit.
//   clk, rst    : clock and asynchronous active-high reset
//   mem_valid   : memory response strobe
//   outstanding : requests accepted but not yet answered
//   count       : entries held in the queue
module fetch_queue_checker #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             mem_valid,
    input logic [CNT_W-1:0] outstanding,
    input logic [CNT_W-1:0] count
);

    // A response is only legal while a request is in flight.
    resp_has_request: assert property (@(posedge clk) disable iff (rst)
        mem_valid |-> (outstanding != {CNT_W{1'b0}}));

    // Queued plus in-flight fetches never exceed the queue capacity.
    credit_bound: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, outstanding} + {1'b0, count}) <= (CNT_W + 1)'(DEPTH)));

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled instruction fetch front end.
// Issues sequential word fetches with a bounded number in flight, buffers the
// returned words with their PCs, and hands them to decode. A redirect loads a
// new PC and flushes both the queue and every fetch still in flight.
//   clk, rst                    : clock, asynchronous active-high reset
//   address_out                 : current fetch PC
//   instruction_mem_request     : fetch request valid
//   instruction_mem_we_re/mask  : constant read / full-word mask
//   instruction_mem_ready       : memory accepts the request this cycle
//   instruction_mem_valid       : in-order response word strobe
//   instruction                 : response word
//   redirect_valid/addr         : load new PC and flush
//   instr_valid/out/pc          : queue head towards decode
//   instr_ready                 : decode consumes the head
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned         ADDRESS      = 32,
    parameter int unsigned         INSTRUCTION  = 32,
    parameter int unsigned         DEPTH        = 4,
    parameter logic [ADDRESS-1:0]  RESET_VECTOR = ADDRESS'(32'h0000_0000)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDRESS-1:0]     address_out,
    output logic                   instruction_mem_request,
    output logic                   instruction_mem_we_re,
    output logic [3:0]             instruction_mem_mask,
    input  logic                   instruction_mem_ready,
    input  logic                   instruction_mem_valid,
    input  logic [INSTRUCTION-1:0] instruction,
    input  logic                   redirect_valid,
    input  logic [ADDRESS-1:0]     redirect_addr,
    output logic                   instr_valid,
    output logic [INSTRUCTION-1:0] instr_out,
    output logic [ADDRESS-1:0]     instr_pc,
    input  logic                   instr_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDRESS-1:0] pc_q, pc_d;
    logic [ADDRESS-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;

    logic [ADDRESS-1:0] redirect_pc_s;
    logic [1:0]         unused_redirect_lsb_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W-1:0]   outstanding_after_resp_s;
    logic [CNT_W:0]     credit_used_s;
    logic               request_s;
    logic               accept_s;
    logic               drop_s;
    logic               push_s;
    logic               pop_s;
    logic               instr_valid_s;
    fetch_entry_t       push_entry_s;
    fetch_entry_t       head_entry_s;

    assign redirect_pc_s         = {redirect_addr[ADDRESS-1:2], 2'b00};
    assign unused_redirect_lsb_s = redirect_addr[1:0];

    // Handshake decode: credit-limited issue, discard of stale responses,
    // and redirect overriding both push and pop.
    always_comb begin
        credit_used_s = {1'b0, count_s} + {1'b0, outstanding_q};
        // rst gating keeps the request low while the core is held in reset.
        request_s     = !rst && !redirect_valid && (credit_used_s < (CNT_W + 1)'(DEPTH));
        accept_s      = request_s && instruction_mem_ready;
        drop_s        = instruction_mem_valid && (discard_q != {CNT_W{1'b0}});
        push_s        = instruction_mem_valid && !drop_s && !redirect_valid;
        instr_valid_s = (count_s != {CNT_W{1'b0}});
        pop_s         = instr_valid_s && instr_ready && !redirect_valid;
        push_entry_s  = '{pc: FETCH_ADDR_W'(resp_pc_q), instr: FETCH_INSTR_W'(instruction)};
    end

    // Next-state for PC, response PC and the in-flight / discard counters.
    always_comb begin
        outstanding_after_resp_s = outstanding_q - CNT_W'(instruction_mem_valid);
        outstanding_d            = outstanding_after_resp_s + CNT_W'(accept_s);
        if (redirect_valid) begin
            pc_d      = redirect_pc_s;
            resp_pc_d = redirect_pc_s;
            // Everything still in flight after this cycle belongs to the old path.
            discard_d = outstanding_after_resp_s;
        end else begin
            if (accept_s) begin
                pc_d = pc_q + ADDRESS'(32'd4);
            end else begin
                pc_d = pc_q;
            end
            if (push_s) begin
                resp_pc_d = resp_pc_q + ADDRESS'(32'd4);
            end else begin
                resp_pc_d = resp_pc_q;
            end
            if (drop_s) begin
                discard_d = discard_q - CNT_W'(32'd1);
            end else begin
                discard_d = discard_q;
            end
        end
    end

    // Front-end state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= {CNT_W{1'b0}};
            discard_q     <= {CNT_W{1'b0}};
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .head_entry (head_entry_s),
        .count      (count_s)
    );

    fetch_queue_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (instruction_mem_valid),
        .outstanding (outstanding_q),
        .count       (count_s)
    );

    assign address_out             = pc_q;
    assign instruction_mem_request = request_s;
    assign instruction_mem_we_re   = 1'b0;
    assign instruction_mem_mask    = FETCH_MASK;
    assign instr_valid             = instr_valid_s;
    assign instr_out               = INSTRUCTION'(head_entry_s.instr);
    assign instr_pc                = ADDRESS'(head_entry_s.pc);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit. A memory model answers accepted
// requests in order after a configurable latency; a scoreboard expects the
// decode stream to be consecutive words from the latest redirect target.
module tb_fetch_queue_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address_out;
    logic        instruction_mem_request;
    logic        instruction_mem_we_re;
    logic [3:0]  instruction_mem_mask;
    logic        instruction_mem_ready;
    logic        instruction_mem_valid;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;

    fetch_queue_unit #(
        .ADDRESS      (32),
        .INSTRUCTION  (32),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .address_out             (address_out),
        .instruction_mem_request (instruction_mem_request),
        .instruction_mem_we_re   (instruction_mem_we_re),
        .instruction_mem_mask    (instruction_mem_mask),
        .instruction_mem_ready   (instruction_mem_ready),
        .instruction_mem_valid   (instruction_mem_valid),
        .instruction             (instruction),
        .redirect_valid          (redirect_valid),
        .redirect_addr           (redirect_addr),
        .instr_valid             (instr_valid),
        .instr_out               (instr_out),
        .instr_pc                (instr_pc),
        .instr_ready             (instr_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;
    int          lat;
    int          n_acc;
    int          n_pop;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_fetch_pc;
    logic [31:0] exp_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ (a * 32'h9E37_79B9);
    endfunction

    // One clock cycle: sample at negedge, update model, then drive memory response.
    task automatic step();
        logic acc;
        logic popd;
        @(negedge clk);
        acc  = instruction_mem_request && instruction_mem_ready;
        popd = instr_valid && instr_ready && !redirect_valid;
        if (acc) begin
            n_checks++;
            if (address_out !== exp_fetch_pc) begin
                n_fail++;
                $display("FAIL fetch_addr cyc=%0d: got %h expected %h", cyc, address_out, exp_fetch_pc);
            end
            pend_addr.push_back(address_out);
            pend_due.push_back(cyc + lat);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            n_acc++;
        end
        if (popd) begin
            n_checks++;
            if (instr_pc !== exp_pop_pc || instr_out !== mem_word(exp_pop_pc)) begin
                n_fail++;
                $display("FAIL decode_head cyc=%0d: got pc %h instr %h expected pc %h instr %h",
                         cyc, instr_pc, instr_out, exp_pop_pc, mem_word(exp_pop_pc));
            end
            exp_pop_pc = exp_pop_pc + 32'd4;
            n_pop++;
        end
        if (redirect_valid) begin
            exp_fetch_pc = redirect_addr & 32'hFFFF_FFFC;
            exp_pop_pc   = redirect_addr & 32'hFFFF_FFFC;
        end
        n_checks++;
        if (pend_addr.size() > DEPTH) begin
            n_fail++;
            $display("FAIL in_flight cyc=%0d: got %0d expected <= %0d", cyc, pend_addr.size(), DEPTH);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            instruction_mem_valid = 1'b1;
            instruction           = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            instruction_mem_valid = 1'b0;
            instruction           = $urandom;
        end
    endtask

    task automatic reset_dut();
        rst                   = 1'b1;
        redirect_valid        = 1'b0;
        redirect_addr         = 32'h0;
        instruction_mem_valid = 1'b0;
        instruction           = 32'h0;
        instruction_mem_ready = 1'b0;
        instr_ready           = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        exp_fetch_pc = RV;
        exp_pop_pc   = RV;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        rst = 1'b0;
        cyc = 0;
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (address_out !== RV || instruction_mem_request !== 1'b0 || instruction_mem_we_re !== 1'b0 ||
            instruction_mem_mask !== 4'hF || instr_valid !== 1'b0 || instr_out !== 32'h0 || instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: got addr %h req %b we %b mask %h v %b instr %h pc %h expected %h 0 0 f 0 0 0",
                     address_out, instruction_mem_request, instruction_mem_we_re, instruction_mem_mask,
                     instr_valid, instr_out, instr_pc, RV);
        end
        release_rst();
        n_checks++;
        if (instruction_mem_request !== 1'b1 || address_out !== RV) begin
            n_fail++;
            $display("FAIL first_request: got req %b addr %h expected 1 %h", instruction_mem_request, address_out, RV);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] t_addr [5];
        logic        t_valid [5];
        logic [31:0] t_pc [5];
        t_addr  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        t_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        t_pc    = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};
        reset_dut();
        release_rst();
        lat = 1;
        instruction_mem_ready = 1'b1;
        instr_ready           = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (address_out !== t_addr[i] || instruction_mem_request !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_addr[%0d]: got %h req %b expected %h 1", i, address_out, instruction_mem_request, t_addr[i]);
            end
            n_checks++;
            if (instr_valid !== t_valid[i] || (t_valid[i] && instr_pc !== t_pc[i])) begin
                n_fail++;
                $display("FAIL seq_head[%0d]: got v %b pc %h expected v %b pc %h", i, instr_valid, instr_pc, t_valid[i], t_pc[i]);
            end
            step();
        end
        repeat (4) step();
        // Redirect timing with 1-cycle memory: empty for two cycles, new word in N+3.
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0040;
        #1;
        n_checks++;
        if (instruction_mem_request !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_req_low: got %b expected 0", instruction_mem_request);
        end
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || address_out !== 32'h40) begin
            n_fail++;
            $display("FAIL redirect_n1: got v %b addr %h expected 0 00000040", instr_valid, address_out);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_n2: got v %b expected 0", instr_valid);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
            n_fail++;
            $display("FAIL redirect_n3: got v %b pc %h expected 1 00000040", instr_valid, instr_pc);
        end
        repeat (4) step();
    endtask

    task automatic test_backpressure();
        int acc0;
        reset_dut();
        release_rst();
        lat = 1;
        instruction_mem_ready = 1'b1;
        instr_ready           = 1'b0;
        acc0 = n_acc;
        repeat (10) step();
        n_checks++;
        if (n_acc - acc0 != DEPTH || instruction_mem_request !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_accepts: got %0d req %b expected %0d 0", n_acc - acc0, instruction_mem_request, DEPTH);
        end
        instr_ready = 1'b1;
        #1;
        n_checks++;
        if (instruction_mem_request !== 1'b0 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_cycle: got req %b v %b expected 0 1", instruction_mem_request, instr_valid);
        end
        step();
        instr_ready = 1'b0;
        #1;
        n_checks++;
        if (instruction_mem_request !== 1'b1 || address_out !== 32'h10) begin
            n_fail++;
            $display("FAIL resume_after_pop: got req %b addr %h expected 1 00000010", instruction_mem_request, address_out);
        end
        instr_ready = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_redirect();
        int pop0;
        reset_dut();
        release_rst();
        lat = 3;
        instruction_mem_ready = 1'b1;
        instr_ready           = 1'b1;
        repeat (2) step();
        n_checks++;
        if (pend_addr.size() != 2) begin
            n_fail++;
            $display("FAIL in_flight_before_redirect: got %0d expected 2", pend_addr.size());
        end
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0103;
        pop0 = n_pop;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (address_out !== 32'h100 || instruction_mem_request !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_addr: got %h req %b expected 00000100 1", address_out, instruction_mem_request);
        end
        repeat (12) step();
        n_checks++;
        if (n_pop - pop0 < 4) begin
            n_fail++;
            $display("FAIL redirect_progress: got %0d pops expected >= 4", n_pop - pop0);
        end
    endtask

    task automatic test_redirect_same_cycle();
        int  pop0;
        bit  found;
        reset_dut();
        release_rst();
        lat = 2;
        instruction_mem_ready = 1'b1;
        instr_ready           = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (cyc > 4 && instruction_mem_valid && instr_valid) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL same_cycle_setup: got none expected mem_valid with instr_valid");
        end
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0200;
        pop0 = n_pop;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_flush: got v %b expected 0", instr_valid);
        end
        repeat (12) step();
        n_checks++;
        if (n_pop - pop0 < 4) begin
            n_fail++;
            $display("FAIL same_cycle_progress: got %0d pops expected >= 4", n_pop - pop0);
        end
    endtask

    task automatic test_random();
        reset_dut();
        release_rst();
        lat = 3;
        for (int i = 0; i < 400; i++) begin
            instruction_mem_ready = ($urandom_range(0, 1) == 1);
            instr_ready           = ($urandom_range(0, 3) != 0);
            redirect_valid        = ($urandom_range(0, 49) == 0);
            redirect_addr         = $urandom;
            step();
            redirect_valid = 1'b0;
        end
        instruction_mem_ready = 1'b0;
        instr_ready           = 1'b1;
        repeat (3 * DEPTH + 10) step();
        n_checks++;
        if (pend_addr.size() != 0 || instr_valid !== 1'b0 || exp_pop_pc !== exp_fetch_pc) begin
            n_fail++;
            $display("FAIL random_drain: got inflight %0d v %b next pop %h expected 0 0 %h",
                     pend_addr.size(), instr_valid, exp_pop_pc, exp_fetch_pc);
        end
        // Fill the queue, then reset asynchronously mid-operation.
        instruction_mem_ready = 1'b1;
        instr_ready           = 1'b0;
        repeat (8) step();
        n_checks++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL refill: got v %b expected 1", instr_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || address_out !== RV || instruction_mem_request !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got v %b addr %h req %b expected 0 %h 0", instr_valid, address_out,
                     instruction_mem_request, RV);
        end
        instruction_mem_valid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
    endtask

    task automatic test_wrap();
        int pop0;
        reset_dut();
        release_rst();
        lat = 1;
        instruction_mem_ready = 1'b1;
        instr_ready           = 1'b1;
        redirect_valid        = 1'b1;
        redirect_addr         = 32'hFFFF_FFFB;
        pop0 = n_pop;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (address_out !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_start: got %h expected fffffff8", address_out);
        end
        step();
        n_checks++;
        if (address_out !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_last: got %h expected fffffffc", address_out);
        end
        step();
        n_checks++;
        if (address_out !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h expected 00000000", address_out);
        end
        repeat (6) step();
        n_checks++;
        if (n_pop - pop0 < 4 || exp_pop_pc[31:16] !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_stream: got %0d pops next %h expected >= 4 pops past wrap", n_pop - pop0, exp_pop_pc);
        end
    endtask

    initial begin
        n_acc = 0;
        n_pop = 0;
        cyc   = 0;
        lat   = 1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction front end for the next-generation RV32I core, replacing the single-address fetch path with a decoupled one. Issues sequential word fetches to instruction memory through a ready/valid handshake with a bounded number of outstanding requests. Buffers returned words with their PCs in a DEPTH-entry queue. Hands instructions to decode through a valid/ready handshake, and supports a one-cycle PC redirect that flushes all buffered and in-flight fetches.

## Interface
- ADDRESS, 32, PC / memory address width
- INSTRUCTION, 32, instruction word width
- DEPTH, 4, queue entries; also the maximum of queued plus outstanding requests; ≥2
- RESET_VECTOR, 32'h0000_0000, PC after reset
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- address_out  out  ADDRESS  fetch address, equal to internal pc
- instruction_mem_request  out  1  fetch request valid
- instruction_mem_we_re  out  1  constant 0 (read)
- instruction_mem_mask  out  4  constant 4'b1111
- instruction_mem_ready  in  1  memory accepts request this cycle
- instruction_mem_valid  in  1  response word valid; responses return in order, ≥1 cycle after acceptance
- instruction  in  INSTRUCTION  response word
- redirect_valid  in  1  load new PC, flush
- redirect_addr  in  ADDRESS  new PC; bits [1:0] forced to 0
- instr_valid  out  1  queue head valid
- instr_out  out  INSTRUCTION  head instruction
- instr_pc  out  ADDRESS  head PC
- instr_ready  in  1  decode consumes head

## Operation
- Registers: pc, resp_pc (PC of next kept response), outstanding, discard_cnt, queue count. Counter width: $clog2(DEPTH+1).
- Issue: request = !redirect_valid && (count + outstanding < DEPTH). Accepted when request && mem_ready, then pc += 4 (mod 2^ADDRESS) and outstanding += 1.
- Response: on mem_valid, outstanding -= 1.
  - If discard_cnt > 0: word dropped, discard_cnt -= 1.
  - Otherwise push {resp_pc, instruction}, then resp_pc += 4.
- Pop: instr_valid && instr_ready removes the head.
- Redirect (highest priority):
  - Queue emptied; pop and push this cycle ignored.
  - pc and resp_pc ← {redirect_addr[ADDRESS-1:2], 2'b00}.
  - discard_cnt ← outstanding after this cycle's response, i.e. all still in flight.
  - request is 0 this cycle; first new fetch is issued the next cycle.
- Simultaneous accept and response: outstanding unchanged.
- Simultaneous push and pop on a full queue is legal; credit rule guarantees no overflow.
- Response with zero outstanding is a protocol error; assertion only, no recovery.

## Timing
- Reset values: address_out = RESET_VECTOR, request 0, we_re 0, mask 4'hF, instr_valid 0, instr_out 0, instr_pc 0; all counters 0; pc = resp_pc = RESET_VECTOR.
- request is asserted in the first cycle after rst deasserts.
- Response to decode latency: word on mem_valid in cycle N is presented as instr_valid in cycle N+1 (registered queue).
- Throughput: one instruction per cycle sustained when memory latency < DEPTH cycles.
- rst asserted mid-operation clears everything immediately. Responses to pre-reset requests must not arrive; memory is reset with the core.
- Redirect in cycle N: instr_valid = 0 in N+1; earliest new instruction valid in N+3 with 1-cycle memory.

## Structure
- Package fetch_pkg holds the fetch_entry_t struct {pc, instr}, the NOP constant 32'h0000_0013, and the mask constant.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH parameter, push/pop/flush, count output.
- Top-level credit, discard and PC logic live in fetch_queue_unit.

## Test plan
- Reset release, mem_ready = 1, 1-cycle latency, words 0x00500093… → address_out 0x0, 0x4, 0x8; instr_pc sequence 0x0, 0x4, 0x8; one per cycle.
- instr_ready = 0 with DEPTH = 4 → exactly 4 requests accepted, then request stays 0; it resumes the cycle after the first pop.
- Redirect to 0x103 with 2 requests outstanding → next address_out 0x100; the 2 late responses are dropped; first instr_pc 0x100.
- Redirect in the same cycle as mem_valid and pop → queue empty next cycle; that response is pushed nowhere; discard_cnt is correct.
- mem_ready toggling randomly with 3-cycle latency → in-order PCs, no loss or duplication, outstanding never exceeds DEPTH.
- PC 0xFFFF_FFFC fetch → next address_out 0x0000_0000 (wrap).
